// File: rtl/readout_pkg.sv
// Shared state encoding and output word layout for the column readout sequencer.
// Frame header words exist only when READOUT_FRAME_HDR_EN is defined.
package readout_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FREEZE,
    S_RD_HI,
    S_RD_LO,
    S_WAIT,
    S_DONE
  } state_t;

  localparam int BCID_W   = 6;
  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 21;
  localparam int WORD_W   = 1 + BCID_W + ADDR_W + DATA_W;
  localparam int FLAG_BIT = WORD_W - 1;
  localparam int FCNT_W   = 16;

  function automatic logic [WORD_W-1:0] hit_word(
    input logic [BCID_W-1:0] b,
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] d
  );
    return {1'b0, b, a, d};
  endfunction

  // Header: flag, spare zero, frame timestamp, pad, frame number.
  function automatic logic [WORD_W-1:0] hdr_word(
    input logic [BCID_W-1:0] b,
    input logic [FCNT_W-1:0] n
  );
    return {1'b1, 1'b0, b, 10'b0, n};
  endfunction

endpackage

// File: rtl/readout_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted only
// when a pop happens on the same edge, otherwise it is dropped and flagged.
module readout_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = wr_q == rd_q;
  assign full    = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign rdata   = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/readout_seq.sv
// Token-driven column readout sequencer with timestamped hit words.
// Define READOUT_FRAME_HDR_EN to emit a numbered header word per frame.
import readout_pkg::*;

module readout_seq #(
  parameter int FREEZE_CYC = 2,
  parameter int READ_HI    = 2,
  parameter int READ_LO    = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              TokIn,
  input  logic [5:0]        ColAddr,
  input  logic [20:0]       ColData,
  output logic              Read,
  output logic              Freeze,
  output logic [5:0]        Bcid,
  output logic [WORD_W-1:0] DataOut,
  output logic              DataValid,
  input  logic              DataReady,
  output logic              Overflow
);

  localparam int CW = 8;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BCID_W-1:0] bcid_q, bcid_d;
  logic [BCID_W-1:0] bfrz_q, bfrz_d;
  logic [1:0]        sync_q, sync_d;
  logic              read_q, read_d;
  logic              frz_q, frz_d;
  logic              ovf_q, ovf_d;
  logic              tok_s;
  logic              push;
  logic [WORD_W-1:0] wdata;
  logic              full, empty, drop;
`ifdef READOUT_FRAME_HDR_EN
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
`endif

  assign tok_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bcid_d  = bcid_q + 6'd1;
    bfrz_d  = bfrz_q;
    sync_d  = {sync_q[0], TokIn};
    push    = 1'b0;
    wdata   = hit_word(bfrz_q, ColAddr, ColData);
`ifdef READOUT_FRAME_HDR_EN
    fcnt_d  = fcnt_q;
`endif
    unique case (state_q)
      S_IDLE: if (tok_s) begin
        state_d = S_FREEZE;
        cnt_d   = '0;
        bfrz_d  = bcid_q;
`ifdef READOUT_FRAME_HDR_EN
        push    = 1'b1;
        wdata   = hdr_word(bcid_q, fcnt_q);
        fcnt_d  = fcnt_q + 16'd1;
`endif
      end
      S_FREEZE: if (cnt_q == CW'(FREEZE_CYC - 1)) begin
        state_d = full ? S_WAIT : S_RD_HI;
        cnt_d   = '0;
      end
      // Capture on the last strobe cycle so the column data has settled.
      S_RD_HI: if (cnt_q == CW'(READ_HI - 1)) begin
        push    = 1'b1;
        state_d = S_RD_LO;
        cnt_d   = '0;
      end
      S_RD_LO: if (cnt_q == CW'(READ_LO - 1)) begin
        cnt_d = '0;
        if (!tok_s)     state_d = S_DONE;
        else if (!full) state_d = S_RD_HI;
        else            state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = '0;
        if (!tok_s)     state_d = S_DONE;
        else if (!full) state_d = S_RD_HI;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    read_d = state_d == S_RD_HI;
    frz_d  = state_d inside {S_FREEZE, S_RD_HI, S_RD_LO, S_WAIT};
    ovf_d  = ovf_q | drop;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bcid_q  <= '0;
      bfrz_q  <= '0;
      sync_q  <= '0;
      read_q  <= 1'b0;
      frz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcid_q  <= bcid_d;
      bfrz_q  <= bfrz_d;
      sync_q  <= sync_d;
      read_q  <= read_d;
      frz_q   <= frz_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef READOUT_FRAME_HDR_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) fcnt_q <= '0;
    else     fcnt_q <= fcnt_d;
  end
`endif

  readout_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .push  (push),
    .wdata (wdata),
    .pop   (DataReady),
    .rdata (DataOut),
    .full  (full),
    .empty (empty),
    .drop  (drop)
  );

  assign Read      = read_q;
  assign Freeze    = frz_q;
  assign Bcid      = bcid_q;
  assign DataValid = !empty;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_readout_seq.sv
// Directed bench for readout_seq: a column model answers Read strobes,
// a sink collects words, and results are checked against expected tables.
module tb_readout_seq;
  import readout_pkg::*;

`ifdef READOUT_FRAME_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic        Clk = 0;
  logic        Rst = 1;
  logic        TokIn = 0;
  logic        DataReady = 0;
  logic [5:0]  ColAddr = '0;
  logic [20:0] ColData = '0;
  logic        Read, Freeze, DataValid, Overflow;
  logic [5:0]  Bcid;
  logic [33:0] DataOut;

  logic        tok2 = 0;
  logic        Read2, Freeze2, Valid2, Ovf2;
  logic [5:0]  Bcid2;
  logic [33:0] Out2;

  int total = 0;
  int bad = 0;
  int cyc;
  int n_hits = 0, hit_i = 0, a_base = 0, d_base = 0, frames = 0;
  logic rd_prev = 0;
  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];

  typedef struct {
    logic rdy;
    logic rd;
    logic fz;
    logic vl;
  } vec_t;
  vec_t tv [10];

  always #5 Clk = ~Clk;

  // Reference timestamp: free-running count of clock edges since reset.
  always @(posedge Clk or posedge Rst)
    if (Rst) cyc <= 0;
    else     cyc <= cyc + 1;

  readout_seq u_dut (
    .Clk(Clk), .Rst(Rst), .TokIn(TokIn),
    .ColAddr(ColAddr), .ColData(ColData),
    .Read(Read), .Freeze(Freeze), .Bcid(Bcid),
    .DataOut(DataOut), .DataValid(DataValid),
    .DataReady(DataReady), .Overflow(Overflow)
  );

  readout_seq #(.READ_HI(3), .READ_LO(1)) u_fast (
    .Clk(Clk), .Rst(Rst), .TokIn(tok2),
    .ColAddr(ColAddr), .ColData(ColData),
    .Read(Read2), .Freeze(Freeze2), .Bcid(Bcid2),
    .DataOut(Out2), .DataValid(Valid2),
    .DataReady(1'b1), .Overflow(Ovf2)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] h_addr(int i);
    return 6'(a_base + i);
  endfunction

  function automatic logic [20:0] h_data(int i);
    return 21'(d_base + i * 'h111);
  endfunction

  // Token detected two edges after TokIn rises; timestamp latched one edge later.
  task automatic col_load(int n, int ab, int db);
    logic [5:0] bf;
    n_hits = n;
    hit_i = 0;
    a_base = ab;
    d_base = db;
    ColAddr = h_addr(0);
    ColData = h_data(0);
    bf = 6'(cyc + 2);
    if (HDR != 0) exp_q.push_back({2'b10, bf, 10'b0, 16'(frames)});
    frames++;
    for (int i = 0; i < n; i++)
      exp_q.push_back({1'b0, bf, h_addr(i), h_data(i)});
    TokIn = n > 0;
  endtask

  task automatic step();
    if (DataValid && DataReady) got_q.push_back(DataOut);
    @(negedge Clk);
    if (Read && !rd_prev && hit_i == n_hits - 1) TokIn = 0;
    if (!Read && rd_prev) begin
      hit_i++;
      ColAddr = h_addr(hit_i);
      ColData = h_data(hit_i);
    end
    rd_prev = Read;
  endtask

  task automatic check_words(string nm);
    chk({nm, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_w%0d", nm, i), 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic h;
    int rises;
    logic old;
    h = HDR != 0;
    tv[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tv[1] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tv[2] = '{1'b0, 1'b0, 1'b1, h};
    tv[3] = '{1'b0, 1'b0, 1'b1, h};
    tv[4] = '{1'b0, 1'b1, 1'b1, h};
    tv[5] = '{1'b0, 1'b1, 1'b1, h};
    tv[6] = '{1'b0, 1'b0, 1'b1, 1'b1};
    tv[7] = '{1'b1, 1'b0, 1'b1, h};
    tv[8] = '{1'b0, 1'b0, 1'b0, h};
    tv[9] = '{1'b0, 1'b0, 1'b0, h};

    #2;
    chk("rst_read", Read, 0);
    chk("rst_freeze", Freeze, 0);
    chk("rst_bcid", Bcid, 0);
    chk("rst_valid", DataValid, 0);
    chk("rst_dout", DataOut, 0);
    chk("rst_ovf", Overflow, 0);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bcid_count", Bcid, 6'(cyc));
    end

    // Single hit, cycle-exact against the table.
    col_load(1, 5, 'hABC);
    for (int j = 0; j < 10; j++) begin
      DataReady = tv[j].rdy;
      step();
      chk($sformatf("single_read_c%0d", j + 1), Read, tv[j].rd);
      chk($sformatf("single_frz_c%0d", j + 1), Freeze, tv[j].fz);
      chk($sformatf("single_vld_c%0d", j + 1), DataValid, tv[j].vl);
    end
    DataReady = 1;
    repeat (4) step();
    DataReady = 0;
    check_words("single");

    // Burst larger than the FIFO with the sink stalled.
    col_load(10, 10, 'h1000);
    rises = 0;
    for (int i = 0; i < 60; i++) begin
      old = rd_prev;
      step();
      if (Read && !old) rises++;
    end
    chk("burst_stall_reads", 64'(rises), 64'(8 - HDR));
    chk("burst_stall_read", Read, 0);
    chk("burst_stall_frz", Freeze, 1);
    chk("burst_stall_vld", DataValid, 1);
    chk("burst_stall_ovf", Overflow, 0);
    DataReady = 1;
    for (int i = 0; i < 80; i++) begin
      old = rd_prev;
      step();
      if (Read && !old) rises++;
      if (hit_i == 10 && !Freeze && !DataValid) break;
    end
    chk("burst_reads", 64'(rises), 10);
    chk("burst_end_frz", Freeze, 0);
    chk("burst_ovf", Overflow, 0);
    DataReady = 0;
    check_words("burst");

    // Frame started with the timestamp at 63.
    for (int i = 0; i < 64 && (cyc % 64) != 61; i++) step();
    chk("wrap_align", 64'(cyc % 64), 61);
    col_load(2, 40, 'h2000);
    step();
    step();
    step();
    chk("wrap_bcid0", Bcid, 0);
    step();
    chk("wrap_bcid1", Bcid, 1);
    step();
    chk("wrap_bcid2", Bcid, 2);
    DataReady = 1;
    repeat (30) step();
    DataReady = 0;
    check_words("wrap");

    // Reset pulse during the third Read strobe.
    col_load(5, 20, 'h3000);
    rises = 0;
    for (int i = 0; i < 40 && rises < 3; i++) begin
      old = rd_prev;
      step();
      if (Read && !old) rises++;
    end
    chk("abort_reached", 64'(rises), 3);
    Rst = 1;
    #1;
    chk("abort_read", Read, 0);
    chk("abort_frz", Freeze, 0);
    chk("abort_vld", DataValid, 0);
    chk("abort_bcid", Bcid, 0);
    TokIn = 0;
    n_hits = 0;
    frames = 0;
    exp_q.delete();
    got_q.delete();
    step();
    step();
    Rst = 0;
    rd_prev = 0;
    repeat (3) step();
    col_load(2, 30, 'h4000);
    DataReady = 1;
    repeat (30) step();
    DataReady = 0;
    check_words("after_rst");

    // Strobe timing with READ_HI=3, READ_LO=1.
    begin
      logic prev2;
      int run, nhi;
      logic seen;
      prev2 = 0;
      run = 0;
      nhi = 0;
      seen = 0;
      tok2 = 1;
      for (int i = 0; i < 40; i++) begin
        if (i == 30) tok2 = 0;
        step();
        if (Read2 == prev2) run++;
        else begin
          if (prev2) begin
            chk($sformatf("fast_hi_run%0d", nhi), 64'(run), 3);
            nhi++;
            seen = 1;
          end else if (seen) begin
            chk($sformatf("fast_lo_run%0d", nhi), 64'(run), 1);
          end
          prev2 = Read2;
          run = 1;
        end
      end
      chk("fast_pulses", 64'(nhi >= 3), 1);
      repeat (10) step();
      chk("fast_end_read", Read2, 0);
      chk("fast_end_frz", Freeze2, 0);
      chk("fast_end_vld", Valid2, 0);
      chk("fast_end_out", Out2, 0);
      chk("fast_ovf", Ovf2, 0);
      chk("fast_bcid", Bcid2, Bcid);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
